// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Digit code that the 7-segment decoder renders as a blank.
    localparam logic [3:0] BCD_BLANK = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // 10**d, used to derive the largest value that fits in d digits.
    function automatic logic [63:0] pow10(input int unsigned d);
        logic [63:0] v;
        v = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    // Conditional +3; wraps within 4 bits, no carry out.
    always_comb begin
        if (i_dig >= 4'd5) begin
            o_dig = i_dig + 4'd3;
        end else begin
            o_dig = i_dig;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts one operand per start/done handshake and blanks the display
// digits when the operand does not fit in D decimal digits.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic             error
);

    localparam int            CW       = $clog2(W + 1);
    localparam logic [63:0]   THRESH   = pow10(D) - 64'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_sr, w_sr_nxt;
    logic [4*D-1:0]   r_dg, w_dg_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [4*D-1:0]   r_bcd, w_bcd_nxt;
    logic             r_error, w_error_nxt;

    logic [4*D-1:0]   w_dg_adj;
    logic [4*D+W-1:0] w_shift;
    logic [63:0]      w_bin_ext;
    logic             w_unused_msb;

    // Per-digit +3 correction ahead of each shift.
    for (genvar k = 0; k < D; k++) begin : g_adj
        bcd_adj3 u_adj (
            .i_dig (r_dg[4*k +: 4]),
            .o_dig (w_dg_adj[4*k +: 4])
        );
    end

    // {dg,sr} shifted left by one; the bit leaving the top digit is dropped
    // (that case is covered by the overflow flag).
    assign w_shift      = {w_dg_adj[4*D-2:0], r_sr, 1'b0};
    assign w_unused_msb = w_dg_adj[4*D-1];
    assign w_bin_ext    = 64'(bin);

    // Next-state and next-register values; defaults hold everything.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_dg_nxt    = r_dg;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_bcd_nxt   = r_bcd;
        w_error_nxt = r_error;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_sr_nxt    = bin;
                    w_dg_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = (w_bin_ext > THRESH);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_CONV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CONV: begin
                w_sr_nxt  = w_shift[W-1:0];
                w_dg_nxt  = w_shift[4*D+W-1:W];
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CNT_LAST) begin
                    if (r_ovf) begin
                        w_bcd_nxt = {D{BCD_BLANK}};
                    end else begin
                        w_bcd_nxt = w_shift[4*D+W-1:W];
                    end
                    w_error_nxt = r_ovf;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CONV;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_dg    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_dg    <= w_dg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_bcd   <= w_bcd_nxt;
            r_error <= w_error_nxt;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign bcd   = r_bcd;
    assign error = r_error;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (W=8/D=3 and W=10/D=3).
module tb_bin_to_bcd_seq;

    logic        Clock;
    logic        Resetn;
    logic        start8, start10;
    logic [7:0]  bin8;
    logic [9:0]  bin10;
    logic        busy8, done8, err8;
    logic        busy10, done10, err10;
    logic [11:0] bcd8, bcd10;

    bit          sel;
    logic        s_busy, s_done, s_err;
    logic [11:0] s_bcd;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          done_at;
    int          prev_done;
    int          cnt_d;
    logic [11:0] prev8  = 12'h000;
    logic [11:0] prev10 = 12'h000;

    bin_to_bcd_seq #(.W(8), .D(3)) u8 (
        .Clock (Clock), .Resetn (Resetn), .start (start8), .bin (bin8),
        .busy (busy8), .done (done8), .bcd (bcd8), .error (err8)
    );

    bin_to_bcd_seq #(.W(10), .D(3)) u10 (
        .Clock (Clock), .Resetn (Resetn), .start (start10), .bin (bin10),
        .busy (busy10), .done (done10), .bcd (bcd10), .error (err10)
    );

    assign s_busy = sel ? busy10 : busy8;
    assign s_done = sel ? done10 : done8;
    assign s_err  = sel ? err10  : err8;
    assign s_bcd  = sel ? bcd10  : bcd8;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref8(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    // Start one conversion, wait (bounded) for done, check result and timing.
    // Returns on the sample where done is high.
    task automatic run(input bit sel_i, input logic [9:0] v, input logic [11:0] eb,
                       input logic ee, input int lat);
        int k;
        int nb;
        logic [11:0] prev;
        sel  = sel_i;
        prev = sel_i ? prev10 : prev8;
        if (sel_i) begin
            start10 = 1'b1;
            bin10   = v;
        end else begin
            start8 = 1'b1;
            bin8   = v[7:0];
        end
        tick;
        start8  = 1'b0;
        start10 = 1'b0;
        bin8    = 8'hFF;
        bin10   = 10'h3FF;
        k  = 0;
        nb = 0;
        while (!s_done && k < 40) begin
            if (s_busy) nb++;
            if (k == lat / 2) chk("hold_bcd", 32'(s_bcd), 32'(prev));
            tick;
            k++;
        end
        done_at = cyc;
        chk("latency", 32'(k), 32'(lat));
        chk("busy_cycles", 32'(nb), 32'(lat));
        chk("bcd", 32'(s_bcd), 32'(eb));
        chk("error", 32'(s_err), 32'(ee));
        chk("busy_at_done", 32'(s_busy), 32'd0);
        if (sel_i) prev10 = eb; else prev8 = eb;
    endtask

    initial begin
        Resetn  = 1'b1;
        start8  = 1'b0;
        start10 = 1'b0;
        bin8    = 8'd0;
        bin10   = 10'd0;
        sel     = 1'b0;
        #2;
        Resetn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_bcd", 32'(bcd8), 32'd0);
        chk("rst_error", 32'(err8), 32'd0);
        chk("rst_bcd10", 32'(bcd10), 32'd0);
        tick;
        Resetn = 1'b1;
        tick;

        // 1: zero operand, single done pulse
        run(1'b0, 10'd0, 12'h000, 1'b0, 8);
        tick;
        chk("t1_done_pulse", 32'(done8), 32'd0);
        chk("t1_idle_busy", 32'(busy8), 32'd0);

        // 2: max operand, then back-to-back start in the done cycle
        run(1'b0, 10'd255, 12'h255, 1'b0, 8);
        run(1'b0, 10'd99, 12'h099, 1'b0, 8);
        tick;

        // 3: start pulses during CONV are ignored
        sel    = 1'b0;
        start8 = 1'b1;
        bin8   = 8'd137;
        tick;
        start8 = 1'b0;
        cnt_d  = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2 || k == 4) begin
                start8 = 1'b1;
                bin8   = 8'd42;
            end else begin
                start8 = 1'b0;
                bin8   = 8'd0;
            end
            if (done8) cnt_d++;
            tick;
        end
        start8 = 1'b0;
        chk("t3_early_done", 32'(cnt_d), 32'd0);
        chk("t3_done", 32'(done8), 32'd1);
        chk("t3_bcd", 32'(bcd8), 32'h137);
        chk("t3_error", 32'(err8), 32'd0);
        prev8 = 12'h137;
        cnt_d = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done8 || busy8) cnt_d++;
        end
        chk("t3_no_extra", 32'(cnt_d), 32'd0);

        // 4: reset mid-conversion
        start8 = 1'b1;
        bin8   = 8'd200;
        tick;
        start8 = 1'b0;
        tick;
        tick;
        tick;
        chk("t4_busy_before", 32'(busy8), 32'd1);
        Resetn = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(busy8), 32'd0);
        chk("t4_rst_done", 32'(done8), 32'd0);
        chk("t4_rst_bcd", 32'(bcd8), 32'd0);
        #1;
        Resetn = 1'b1;
        prev8  = 12'h000;
        cnt_d  = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done8 || busy8) cnt_d++;
        end
        chk("t4_no_done", 32'(cnt_d), 32'd0);
        run(1'b0, 10'd7, 12'h007, 1'b0, 8);
        tick;

        // 5: W=10 overflow boundary
        run(1'b1, 10'd999, 12'h999, 1'b0, 10);
        tick;
        run(1'b1, 10'd1000, 12'hAAA, 1'b1, 10);
        tick;
        run(1'b1, 10'd5, 12'h005, 1'b0, 10);
        tick;

        // 6: full sweep, back-to-back
        prev_done = 0;
        for (int v = 0; v < 256; v++) begin
            run(1'b0, 10'(v), ref8(v), 1'b0, 8);
            if (v > 0) chk("sweep_spacing", 32'(done_at - prev_done), 32'd9);
            prev_done = done_at;
        end
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
